// File: rtl/fp_mult_core_seq_if.sv
// Handshake and result bundle for fp_mult_core_seq: operand valid/ready in,
// rounding-stage input set out.
interface fp_mult_core_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] mantissa;
  logic        guard;
  logic        sticky;
  logic        sign_mult;
  logic [9:0]  exp_out;
  logic [1:0]  special;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, mantissa, guard, sticky, sign_mult, exp_out, special
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, mantissa, guard, sticky, sign_mult, exp_out, special
  );
endinterface

// File: rtl/fp_mult_core_seq.sv
// Iterative binary32 multiplier datapath: 24-cycle radix-2 shift-add plus one normalize cycle.
// Define FP_MULT_EARLY_EXIT_EN to send special-case operands straight to DONE one edge after acceptance.
module fp_mult_core_seq (
  input  logic              clk,
  input  logic              rst,
  fp_mult_core_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  localparam logic [1:0] SPC_NORMAL = 2'b00;
  localparam logic [1:0] SPC_ZERO   = 2'b01;
  localparam logic [1:0] SPC_INF    = 2'b10;
  localparam logic [1:0] SPC_NAN    = 2'b11;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [23:0] ma, mb;
  logic [7:0]  ea, eb;
  logic [47:0] acc;
  logic        sign_r;
  logic [1:0]  special_r;
  logic        accept, load_out;

  logic [7:0]  ea_in, eb_in;
  logic [22:0] fa_in, fb_in;
  logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [1:0]  special_in;

  logic [9:0]  exp_sum;
  logic [23:0] norm_mant;
  logic        norm_guard, norm_sticky;
  logic [9:0]  norm_exp;

  assign ea_in = bus.a[30:23];
  assign fa_in = bus.a[22:0];
  assign eb_in = bus.b[30:23];
  assign fb_in = bus.b[22:0];

  // Denormals count as zero, so a zero exponent alone classifies an operand as zero.
  assign zero_a = (ea_in == 8'd0);
  assign zero_b = (eb_in == 8'd0);
  assign inf_a  = (ea_in == 8'hFF) && (fa_in == 23'd0);
  assign inf_b  = (eb_in == 8'hFF) && (fb_in == 23'd0);
  assign nan_a  = (ea_in == 8'hFF) && (fa_in != 23'd0);
  assign nan_b  = (eb_in == 8'hFF) && (fb_in != 23'd0);

  always_comb begin
    special_in = SPC_NORMAL;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) special_in = SPC_NAN;
    else if (inf_a || inf_b)                                      special_in = SPC_INF;
    else if (zero_a || zero_b)                                    special_in = SPC_ZERO;
  end

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && (state == IDLE);

  assign exp_sum = {2'b00, ea} + {2'b00, eb};

  always_comb begin
    if (acc[47]) begin
      norm_mant   = acc[47:24];
      norm_guard  = acc[23];
      norm_sticky = |acc[22:0];
      norm_exp    = exp_sum - 10'd126;
    end else begin
      norm_mant   = acc[46:23];
      norm_guard  = acc[22];
      norm_sticky = |acc[21:0];
      norm_exp    = exp_sum - 10'd127;
    end
  end

  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    case (state)
      IDLE: if (accept) state_next = MUL;
      MUL: begin
`ifdef FP_MULT_EARLY_EXIT_EN
        if (special_r != SPC_NORMAL) begin
          state_next = DONE;
          load_out   = 1'b1;
        end else
`endif
        if (cnt == 5'd23) state_next = NORM;
      end
      NORM: begin
        state_next = DONE;
        load_out   = 1'b1;
      end
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 5'd0;
      ma            <= 24'd0;
      mb            <= 24'd0;
      ea            <= 8'd0;
      eb            <= 8'd0;
      acc           <= 48'd0;
      sign_r        <= 1'b0;
      special_r     <= SPC_NORMAL;
      bus.out_valid <= 1'b0;
      bus.mantissa  <= 24'd0;
      bus.guard     <= 1'b0;
      bus.sticky    <= 1'b0;
      bus.sign_mult <= 1'b0;
      bus.exp_out   <= 10'd0;
      bus.special   <= SPC_NORMAL;
    end else begin
      state         <= state_next;
      bus.out_valid <= (state_next == DONE);

      if (accept) begin
        ea        <= ea_in;
        eb        <= eb_in;
        ma        <= zero_a ? 24'd0 : {1'b1, fa_in};
        mb        <= zero_b ? 24'd0 : {1'b1, fb_in};
        acc       <= 48'd0;
        cnt       <= 5'd0;
        sign_r    <= bus.a[31] ^ bus.b[31];
        special_r <= special_in;
      end

      if (state == MUL) begin
        if (mb[cnt]) acc <= acc + ({24'd0, ma} << cnt);
        cnt <= cnt + 5'd1;
      end

      // Special results carry only sign and code; the datapath fields are forced to zero.
      if (load_out) begin
        bus.sign_mult <= sign_r;
        bus.special   <= special_r;
        if (special_r == SPC_NORMAL) begin
          bus.mantissa <= norm_mant;
          bus.guard    <= norm_guard;
          bus.sticky   <= norm_sticky;
          bus.exp_out  <= norm_exp;
        end else begin
          bus.mantissa <= 24'd0;
          bus.guard    <= 1'b0;
          bus.sticky   <= 1'b0;
          bus.exp_out  <= 10'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_core_seq.sv
// Self-checking bench for fp_mult_core_seq: arithmetic reference model, per-cycle compare,
// directed test-plan vectors, reset abort, backpressure and randomized operands.
module tb_fp_mult_core_seq;

  typedef struct packed {
    logic [23:0] mant;
    logic        guard;
    logic        sticky;
    logic        sign;
    logic [9:0]  exp;
    logic [1:0]  special;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fp_mult_core_seq_if bus ();

  fp_mult_core_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   chk_en = 1'b0;
  bit   busy   = 1'b0;
  int   acc_cycle = 0;
  int   lat_cur   = 25;
  res_t exp_cur;
  bit   cmp_valid;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, expv, cycle);
    end
  endtask

  function automatic res_t mk_res(input logic [23:0] m, input logic g, input logic s,
                                  input logic sg, input logic [9:0] e, input logic [1:0] sp);
    res_t r;
    r.mant = m; r.guard = g; r.sticky = s; r.sign = sg; r.exp = e; r.special = sp;
    return r;
  endfunction

  // Reference: classify operands, then take the exact 48-bit product of the significands.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    logic [7:0]  ex, ey;
    logic [63:0] sx, sy, p;
    bit          zx, zy, ix, iy, nx, ny;
    int          e;
    ex = x[30:23]; ey = y[30:23];
    zx = (ex == 0); zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0); iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0); ny = (ey == 255) && (y[22:0] != 0);
    r = '0;
    r.sign = x[31] ^ y[31];
    if (nx || ny || (ix && zy) || (iy && zx)) r.special = 2'b11;
    else if (ix || iy)                        r.special = 2'b10;
    else if (zx || zy)                        r.special = 2'b01;
    else begin
      sx = 64'h800000 + 64'(x[22:0]);
      sy = 64'h800000 + 64'(y[22:0]);
      p  = sx * sy;
      if (p[47]) begin
        r.mant   = p[47:24];
        r.guard  = p[23];
        r.sticky = (p[22:0] != 0);
        e = int'(ex) + int'(ey) - 126;
      end else begin
        r.mant   = p[46:23];
        r.guard  = p[22];
        r.sticky = (p[21:0] != 0);
        e = int'(ex) + int'(ey) - 127;
      end
      r.exp = e[9:0];
    end
    return r;
  endfunction

  function automatic int lat_for(input res_t r);
`ifdef FP_MULT_EARLY_EXIT_EN
    if (r.special != 2'b00) return 1;
`endif
    return 25;
  endfunction

  // Model bookkeeping on each rising edge: acceptance, result handshake, reset abort.
  always @(posedge clk) begin
    bit valid_now;
    valid_now = busy && (cycle - acc_cycle >= lat_cur);
    cycle++;
    if (rst) busy = 1'b0;
    else if (valid_now && bus.out_ready) busy = 1'b0;
    else if (!busy && bus.in_valid) begin
      busy      = 1'b1;
      acc_cycle = cycle;
      exp_cur   = model(bus.a, bus.b);
      lat_cur   = lat_for(exp_cur);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_valid = busy && (cycle - acc_cycle >= lat_cur);
      checkOutput("in_ready", 64'(bus.in_ready), 64'(!busy));
      checkOutput("out_valid", 64'(bus.out_valid), 64'(cmp_valid));
      if (cmp_valid) begin
        checkOutput("mantissa", 64'(bus.mantissa), 64'(exp_cur.mant));
        checkOutput("guard", 64'(bus.guard), 64'(exp_cur.guard));
        checkOutput("sticky", 64'(bus.sticky), 64'(exp_cur.sticky));
        checkOutput("sign_mult", 64'(bus.sign_mult), 64'(exp_cur.sign));
        checkOutput("exp_out", 64'(bus.exp_out), 64'(exp_cur.exp));
        checkOutput("special", 64'(bus.special), 64'(exp_cur.special));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] xa, input logic [31:0] xb, input int bp,
                               output res_t res, output int lat);
    int n;
    res = '0;
    lat = 0;
    @(negedge clk);
    bus.a = xa; bus.b = xb; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout actual=no_accept expected=accept");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      bus.in_valid = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
      @(negedge clk);
      lat++; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("[TB] FAIL done_timeout actual=no_out_valid expected=out_valid");
      bus.in_valid = 1'b0;
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      return;
    end
    res = {bus.mantissa, bus.guard, bus.sticky, bus.sign_mult, bus.exp_out, bus.special};
    repeat (bp) begin
      bus.in_valid = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [31:0] xa, input logic [31:0] xb,
                       input int bp, input bit use_lit, input res_t lit);
    res_t r, m;
    int   lat;
    m = model(xa, xb);
    if (use_lit) checkOutput({name, "_model"}, 64'(m), 64'(lit));
    applyStimulus(xa, xb, bp, r, lat);
    if (use_lit) checkOutput({name, "_dut"}, 64'(r), 64'(lit));
    checkOutput({name, "_latency"}, 64'(lat), 64'(lat_for(m)));
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      2: v[30:23] = 8'hFF;
      3: v[22:0] = 23'h7FFFFF;
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  initial begin
    res_t r;
    int   lat;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r = {bus.mantissa, bus.guard, bus.sticky, bus.sign_mult, bus.exp_out, bus.special};
    checkOutput("reset_outputs", 64'(r), 64'(0));
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(1));
    chk_en = 1'b1;

    runOp("one_x_one", 32'h3F800000, 32'h3F800000, 0, 1'b1,
          mk_res(24'h800000, 1'b0, 1'b0, 1'b0, 10'd127, 2'b00));
    runOp("onept5_sq", 32'h3FC00000, 32'h3FC00000, 2, 1'b1,
          mk_res(24'h900000, 1'b0, 1'b0, 1'b0, 10'd128, 2'b00));
    runOp("sticky_vec", 32'hBF800001, 32'h3F800001, 1, 1'b1,
          mk_res(24'h800002, 1'b0, 1'b1, 1'b1, 10'd127, 2'b00));
    runOp("inf_x_zero", 32'h7F800000, 32'h00000000, 0, 1'b1,
          mk_res(24'h0, 1'b0, 1'b0, 1'b0, 10'd0, 2'b11));
    runOp("backpressure", 32'h40400000, 32'h40000000, 10, 1'b1,
          mk_res(24'hC00000, 1'b0, 1'b0, 1'b0, 10'd129, 2'b00));
    runOp("neg_inf", 32'hFF800000, 32'h3F800000, 3, 1'b1,
          mk_res(24'h0, 1'b0, 1'b0, 1'b1, 10'd0, 2'b10));

    // Abort an operation while the multiply loop is at cnt=10.
    @(negedge clk);
    bus.a = 32'h40490FDB; bus.b = 32'h402DF854; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r = {bus.mantissa, bus.guard, bus.sticky, bus.sign_mult, bus.exp_out, bus.special};
    checkOutput("abort_outputs_cleared", 64'(r), 64'(0));
    checkOutput("abort_in_ready", 64'(bus.in_ready), 64'(1));
    repeat (30) @(negedge clk);
    runOp("after_abort", 32'h40490FDB, 32'h402DF854, 1, 1'b0, '0);

    for (int i = 0; i < 40; i++) begin
      runOp("random", rand_operand(), rand_operand(), int'($urandom_range(0, 3)), 1'b0, '0);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fp_mult_core_seq.md
# fp_mult_core_seq

Iterative single-precision multiplier datapath. It sits directly upstream of the multiplier rounding stage and produces that stage's full input set: 24-bit normalized mantissa, guard, sticky, product sign, plus biased exponent and special-case code. Operands are accepted over a valid/ready handshake. A 24-cycle radix-2 shift-add loop forms the product, followed by one normalization cycle. The result is held under output backpressure.

## Interface
Parameters:
- None; widths are fixed by IEEE-754 binary32.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a, b  in  32  IEEE-754 binary32 operands
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  consumer takes result
- mantissa  out  24  normalized product mantissa, hidden bit at [23]
- guard  out  1  first bit below mantissa LSB
- sticky  out  1  OR of all bits below guard
- sign_mult  out  1  a[31] ^ b[31]
- exp_out  out  10  biased result exponent, two's complement
- special  out  2  00 normal, 01 zero, 10 infinity, 11 NaN

## Operation
- States: IDLE, MUL, NORM, DONE.
- IDLE: in_ready=1. A handshake (in_valid & in_ready) latches the operands and goes to MUL with cnt=0.
- Latch step:
  - ma={|ea,fa}, mb={|eb,fb}.
  - Denormals are flushed: exponent 0 gives a zero operand.
  - acc(48)=0.
- MUL: each cycle, if mb[cnt] then acc += ma<<cnt; cnt++. After cnt=23 the next state is NORM.
- NORM, product P=acc:
  - If P[47]: mantissa=P[47:24], guard=P[23], sticky=|P[22:0], exp_out=ea+eb-126.
  - Else: mantissa=P[46:23], guard=P[22], sticky=|P[21:0], exp_out=ea+eb-127.
  - Then go to DONE.
- Special code, priority order:
  - NaN if either operand is NaN, or inf×zero.
  - Else inf if either operand is inf.
  - Else zero if either operand is zero.
  - Else normal.
  - For any non-normal code: mantissa=0, guard=0, sticky=0, exp_out=0. sign_mult is always valid.
- Exponent overflow/underflow is not detected here. exp_out spans -125..382 in 10-bit signed and is left to the downstream stage.
- DONE: out_valid=1, and all outputs hold stable until out_ready=1. On out_ready the next state is IDLE. in_valid is ignored in every state except IDLE.
- Only one operation is in flight; there is no overlap between a result in DONE and a new acceptance.

## Timing
- Reset: rst high at a rising edge forces state=IDLE and cnt=0. Registered outputs clear: mantissa=0, guard=0, sticky=0, sign_mult=0, exp_out=0, special=00, out_valid=0. From the next cycle in_ready=1.
- Reset mid-operation (MUL/NORM/DONE) discards the operation; no out_valid is produced for it.
- Latency (no early exit): acceptance edge E0; MUL iterations on E1..E24; NORM at E25; out_valid high after E25.
- Throughput: at best one result per 27 cycles, because out_ready at E26 gives IDLE for the cycle after E26.
- in_ready is combinational from state only, with no path from in_valid.
- out_valid and all data outputs are registered.

## Configuration
- Macro: FP_MULT_EARLY_EXIT_EN.
- Defined: when the special code is non-normal at acceptance, the block skips MUL/NORM and goes directly to DONE at E1. out_valid is high after E1.
- Undefined: every operation takes the full 25-edge path, and special results appear with the same timing as normal ones.

## Test plan
- 0x3F800000 × 0x3F800000 -> mantissa 0x800000, guard 0, sticky 0, exp_out 127, sign 0, special 00; out_valid exactly 25 edges after acceptance.
- 0x3FC00000 × 0x3FC00000 (1.5²) -> P[47]=1: mantissa 0x900000, exp_out 128, guard 0, sticky 0.
- 0xBF800001 × 0x3F800001 -> mantissa 0x800002, guard 0, sticky 1, exp_out 127, sign_mult 1.
- 0x7F800000 × 0x00000000 -> special 11, mantissa 0. out_valid after 1 edge with FP_MULT_EARLY_EXIT_EN, after 25 edges without it.
- Backpressure: out_ready low for 10 cycles in DONE with in_valid toggling -> outputs stable, in_ready 0, no new acceptance. out_ready=1 -> IDLE next cycle; the next operand pair is accepted with correct result.
- rst pulsed one cycle at MUL cnt=10 -> out_valid never rises for that operation; in_ready=1 the following cycle; next operation completes normally.
